// File: rtl/ctrl_decode_pipe.sv
// Main control decoder fused with the ID/EX control register.
// Detects load-use hazards, honours flushes, counts illegal opcodes.
module ctrl_decode_pipe #(
  parameter logic        SUPPORT_JAL    = 1'b1,
  parameter logic        SUPPORT_LUI    = 1'b1,
  parameter logic        LOAD_USE_STALL = 1'b1,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [31:0]      instr_i,
  input  logic             flush_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_rd_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic             alu_src_o,
  output logic             mem_to_reg_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             branch_o,
  output logic             reg_write_o,
  output logic             jump_o,
  output logic [1:0]       alu_op_o,
  output logic [4:0]       rd_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_NOP  = 7'b0000000;

  logic [6:0] op;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [8:0] dec_ctl;
  logic       known;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       illegal;
  logic       hazard;
  logic       issue;
  logic       cnt_inc;

  logic [8:0]       ctl_q, ctl_d;
  logic [4:0]       rd_q, rd_d;
  logic             valid_q, valid_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic unused_bits;

  assign op  = instr_i[6:0];
  assign rs1 = instr_i[19:15];
  assign rs2 = instr_i[24:20];
  assign unused_bits = ^{instr_i[31:25], instr_i[14:12]};

  // Opcode decode: {alu_src,mem_to_reg,mem_read,mem_write,branch,reg_write,jump,alu_op}
  always_comb begin
    dec_ctl  = '0;
    known    = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    unique case (1'b1)
      (op == OP_R): begin
        dec_ctl  = 9'b0_0_0_0_0_1_0_10;
        known    = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      (op == OP_LW): begin
        dec_ctl  = 9'b1_1_1_0_0_1_0_00;
        known    = 1'b1;
        uses_rs1 = 1'b1;
      end
      (op == OP_SW): begin
        dec_ctl  = 9'b1_0_0_1_0_0_0_00;
        known    = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      (op == OP_BR): begin
        dec_ctl  = 9'b0_0_0_0_1_0_0_11;
        known    = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      (op == OP_ADDI): begin
        dec_ctl  = 9'b1_0_0_0_0_1_0_00;
        known    = 1'b1;
        uses_rs1 = 1'b1;
      end
      (op == OP_JAL && SUPPORT_JAL): begin
        dec_ctl  = 9'b1_0_0_0_0_1_1_00;
        known    = 1'b1;
      end
      (op == OP_LUI && SUPPORT_LUI): begin
        dec_ctl  = 9'b1_0_0_0_0_1_0_01;
        known    = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = (op != OP_NOP) & ~known;

  assign hazard = valid_i & ~flush_i & ex_mem_read_i
                & (ex_rd_i != 5'd0)
                & ((uses_rs1 & (rs1 == ex_rd_i))
                 | (uses_rs2 & (rs2 == ex_rd_i)));

  assign stall_o = LOAD_USE_STALL & hazard;

  assign issue   = valid_i & ~flush_i & ~stall_o & known;
  assign cnt_inc = valid_i & ~flush_i & ~stall_o & illegal;

  // Next-state: bundle or bubble, sticky flag, saturating counter
  always_comb begin
    valid_d = issue;
    ctl_d   = issue ? dec_ctl : '0;
    rd_d    = issue ? instr_i[11:7] : '0;
    ill_d   = ill_q | cnt_inc;
    cnt_d   = cnt_q;
    if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ID/EX control register with async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctl_q   <= '0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctl_q   <= ctl_d;
      rd_q    <= rd_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o = valid_q;
  assign {alu_src_o, mem_to_reg_o, mem_read_o, mem_write_o,
          branch_o, reg_write_o, jump_o, alu_op_o} = ctl_q;
  assign rd_o          = rd_q;
  assign illegal_o     = ill_q;
  assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench: two decoder configurations on shared stimulus,
// scoreboard against an opcode-table reference model.
module tb_ctrl_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic        flush_i = 1'b0;
  logic        ex_mem_read_i = 1'b0;
  logic [4:0]  ex_rd_i = '0;

  logic       st0, v0, as0, mr20, rd0m, wr0, br0, rw0, j0, il0;
  logic [1:0] op0;
  logic [4:0] rd0;
  logic [7:0] cnt0;
  logic       st1, v1, as1, mr21, rd1m, wr1, br1, rw1, j1, il1;
  logic [1:0] op1;
  logic [4:0] rd1;
  logic [1:0] cnt1;

  always #5 clk = ~clk;

  ctrl_decode_pipe dut0 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .instr_i(instr_i),
    .flush_i(flush_i), .ex_mem_read_i(ex_mem_read_i), .ex_rd_i(ex_rd_i),
    .stall_o(st0), .valid_o(v0), .alu_src_o(as0), .mem_to_reg_o(mr20),
    .mem_read_o(rd0m), .mem_write_o(wr0), .branch_o(br0),
    .reg_write_o(rw0), .jump_o(j0), .alu_op_o(op0), .rd_o(rd0),
    .illegal_o(il0), .illegal_cnt_o(cnt0)
  );

  ctrl_decode_pipe #(
    .SUPPORT_JAL(1'b0), .SUPPORT_LUI(1'b0),
    .LOAD_USE_STALL(1'b0), .CNT_W(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .instr_i(instr_i),
    .flush_i(flush_i), .ex_mem_read_i(ex_mem_read_i), .ex_rd_i(ex_rd_i),
    .stall_o(st1), .valid_o(v1), .alu_src_o(as1), .mem_to_reg_o(mr21),
    .mem_read_o(rd1m), .mem_write_o(wr1), .branch_o(br1),
    .reg_write_o(rw1), .jump_o(j1), .alu_op_o(op1), .rd_o(rd1),
    .illegal_o(il1), .illegal_cnt_o(cnt1)
  );

  wire [24:0] a0 = {st0, v0, as0, mr20, rd0m, wr0, br0, rw0, j0,
                    op0, rd0, il0, cnt0};
  wire [24:0] a1 = {st1, v1, as1, mr21, rd1m, wr1, br1, rw1, j1,
                    op1, rd1, il1, 6'd0, cnt1};

  typedef struct packed {
    logic [24:0] e0;
    logic [24:0] e1;
    int          id;
  } rec_t;

  rec_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   nvec = 0;

  logic [8:0] tbl [int];
  int         mcnt [2];
  bit         mill [2];

  function automatic logic [24:0] model(
    input int d, input bit v, input logic [31:0] ins,
    input bit fl, input bit exmr, input logic [4:0] exrd);
    int  op   = int'(ins[6:0]);
    int  w    = (d == 0) ? 8 : 2;
    bit  full = (d == 0);
    bit  known;
    bit  ill;
    bit  u1;
    bit  u2;
    bit  st;
    bit  iss;
    known = tbl.exists(op) && (full || (op != 'h6F && op != 'h37));
    ill   = !known && op != 0;
    u1    = known && op != 'h6F && op != 'h37;
    u2    = known && (op == 'h33 || op == 'h23 || op == 'h63);
    st    = full && v && !fl && exmr && exrd != 0 &&
            ((u1 && ins[19:15] == exrd) || (u2 && ins[24:20] == exrd));
    iss   = v && !fl && !st && known;
    if (v && !fl && !st && ill) begin
      mill[d] = 1'b1;
      if (mcnt[d] < (1 << w) - 1) mcnt[d] = mcnt[d] + 1;
    end
    return {st, iss, iss ? tbl[op] : 9'd0, iss ? ins[11:7] : 5'd0,
            mill[d], 8'(mcnt[d])};
  endfunction

  function automatic logic [31:0] mk(
    input logic [6:0] op, input logic [4:0] rd,
    input logic [4:0] rs1, input logic [4:0] rs2);
    logic [31:0] r;
    r = $urandom();
    r[6:0]   = op;
    r[11:7]  = rd;
    r[19:15] = rs1;
    r[24:20] = rs2;
    return r;
  endfunction

  task automatic cyc(input bit v, input logic [31:0] ins,
                     input bit fl, input bit exmr, input logic [4:0] exrd);
    rec_t r;
    @(negedge clk);
    #1;
    valid_i = v;
    instr_i = ins;
    flush_i = fl;
    ex_mem_read_i = exmr;
    ex_rd_i = exrd;
    r.e0 = model(0, v, ins, fl, exmr, exrd);
    r.e1 = model(1, v, ins, fl, exmr, exrd);
    r.id = nvec;
    nvec++;
    q.push_back(r);
  endtask

  task automatic check_zero(input string nm);
    vectors += 2;
    if (a0 !== 25'd0) begin
      miscompares++;
      $display("FAIL %s dut0: got %h expected 0", nm, a0);
    end
    if (a1 !== 25'd0) begin
      miscompares++;
      $display("FAIL %s dut1: got %h expected 0", nm, a1);
    end
  endtask

  // Monitor: outputs for each issued vector settle just after the edge
  initial begin
    rec_t r;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        r = q.pop_front();
        vectors += 2;
        if (a0 !== r.e0) begin
          miscompares++;
          $display("FAIL vec%0d dut0: got %h expected %h", r.id, a0, r.e0);
        end
        if (a1 !== r.e1) begin
          miscompares++;
          $display("FAIL vec%0d dut1: got %h expected %h", r.id, a1, r.e1);
        end
      end
    end
  end

  initial begin
    logic [6:0] ops [8];
    logic [6:0] o;
    logic [31:0] ins;
    tbl['h33] = 9'b0_0_0_0_0_1_0_10;
    tbl['h03] = 9'b1_1_1_0_0_1_0_00;
    tbl['h23] = 9'b1_0_0_1_0_0_0_00;
    tbl['h63] = 9'b0_0_0_0_1_0_0_11;
    tbl['h13] = 9'b1_0_0_0_0_1_0_00;
    tbl['h6F] = 9'b1_0_0_0_0_1_1_00;
    tbl['h37] = 9'b1_0_0_0_0_1_0_01;
    ops = '{7'h33, 7'h03, 7'h23, 7'h63, 7'h13, 7'h6F, 7'h37, 7'h00};
    mcnt[0] = 0; mcnt[1] = 0;
    mill[0] = 0; mill[1] = 0;

    #12;
    check_zero("reset");
    rst_n = 1'b1;

    cyc(1, 32'h0000A283, 0, 0, 0);
    cyc(1, mk(7'h33, 6, 5, 2), 0, 1, 5);
    cyc(1, mk(7'h33, 6, 5, 2), 0, 0, 5);
    cyc(1, mk(7'h33, 6, 5, 2), 0, 1, 0);
    cyc(1, mk(7'h37, 5, 5, 5), 0, 1, 5);
    cyc(1, mk(7'h23, 0, 5, 3), 1, 1, 5);
    cyc(1, mk(7'h23, 0, 3, 5), 0, 1, 5);
    cyc(1, mk(7'h6F, 1, 0, 0), 0, 0, 0);
    cyc(1, mk(7'h6F, 1, 0, 0), 0, 0, 0);
    cyc(1, mk(7'h6F, 1, 0, 0), 0, 0, 0);
    cyc(1, 32'h0000A283, 0, 0, 0);

    @(posedge clk);
    #3;
    valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    mcnt[0] = 0; mcnt[1] = 0;
    mill[0] = 0; mill[1] = 0;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) cyc(1, mk(7'h7F, 2, 1, 1), 0, 0, 0);
    cyc(1, mk(7'h7F, 2, 1, 1), 1, 0, 0);
    cyc(1, mk(7'h00, 0, 0, 0), 0, 0, 0);
    cyc(0, mk(7'h13, 4, 1, 1), 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) == 0) o = 7'($urandom());
      else o = ops[$urandom_range(7)];
      ins = mk(o, 5'($urandom_range(7)), 5'($urandom_range(3)),
               5'($urandom_range(3)));
      cyc($urandom_range(7) != 0, ins, $urandom_range(7) == 0,
          $urandom_range(1) == 1, 5'($urandom_range(3)));
    end

    @(negedge clk);
    valid_i = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
